// File: rtl/cp0_exception_unit.sv
// cp0_exception_unit: CP0 register file, Count/Compare timer and exception flush/redirect sequencer
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InstValid,
  input  logic [31:0] InstPC,
  input  logic        InDelaySlot,
  input  logic        ExcSyscall,
  input  logic        ExcEret,
  input  logic        CP0WE,
  input  logic [4:0]  CP0WAddr,
  input  logic [31:0] CP0WData,
  input  logic        CP0RE,
  input  logic [4:0]  CP0RAddr,
  output logic [31:0] CP0RData,
  input  logic [5:0]  HwInt,
  output logic        FlushReq,
  output logic        RedirectValid,
  output logic [31:0] RedirectPC,
  input  logic        RedirectAck,
  output logic        Busy
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
  state_t state, nxt;
  logic [31:0] count, compare, epc, tgt, status_v, cause_v;
  logic [7:0] im, ip;
  logic [5:0] hw_q;
  logic [4:0] exc_code;
  logic [1:0] sw_ip;
  logic ie, exl, bd, tp;
  logic idle, accept, int_pend, take_int, take_sys, take_eret, exc, we;
  logic w9, w11, w12, w13, w14;
  assign idle      = state == IDLE;
  assign accept    = idle && InstValid;
  assign ip        = {hw_q[5] | tp, hw_q[4:0], sw_ip};
  assign int_pend  = ie && !exl && |(ip & im);
  assign take_int  = accept && int_pend;
  assign take_sys  = accept && !int_pend && ExcSyscall;
  assign take_eret = accept && !int_pend && !ExcSyscall && ExcEret;
  assign exc       = take_int || take_sys;
  // an interrupt cancels the commit instruction, including its MTC0
  assign we  = CP0WE && idle && !take_int;
  assign w9  = we && CP0WAddr == 5'd9;
  assign w11 = we && CP0WAddr == 5'd11;
  assign w12 = we && CP0WAddr == 5'd12;
  assign w13 = we && CP0WAddr == 5'd13;
  assign w14 = we && CP0WAddr == 5'd14;
  assign status_v = {16'b0, im, 6'b0, exl, ie};
  assign cause_v  = {bd, 15'b0, ip, 1'b0, exc_code, 2'b0};
  assign CP0RData = !CP0RE ? 32'b0 :
                    CP0RAddr == 5'd9  ? count :
                    CP0RAddr == 5'd11 ? compare :
                    CP0RAddr == 5'd12 ? status_v :
                    CP0RAddr == 5'd13 ? cause_v :
                    CP0RAddr == 5'd14 ? epc : 32'b0;
  assign FlushReq      = state == FLUSH;
  assign RedirectValid = state == REDIRECT;
  assign RedirectPC    = state == REDIRECT ? tgt : 32'b0;
  assign Busy          = !idle;
  always_comb begin
    nxt = state;
    nxt = state == IDLE  ? ((exc || take_eret) ? FLUSH : IDLE) :
          state == FLUSH ? REDIRECT :
          RedirectAck    ? IDLE : REDIRECT;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      compare  <= 32'hFFFF_FFFF;
      epc      <= '0;
      tgt      <= '0;
      im       <= '0;
      hw_q     <= '0;
      exc_code <= '0;
      sw_ip    <= '0;
      ie       <= 1'b0;
      exl      <= 1'b0;
      bd       <= 1'b0;
      tp       <= 1'b0;
    end else begin
      state    <= nxt;
      hw_q     <= HwInt;
      count    <= w9 ? CP0WData : count + 32'd1;
      compare  <= w11 ? CP0WData : compare;
      tp       <= w11 ? 1'b0 : (tp || count == compare);
      ie       <= w12 ? CP0WData[0] : ie;
      im       <= w12 ? CP0WData[15:8] : im;
      exl      <= exc ? 1'b1 : take_eret ? 1'b0 : w12 ? CP0WData[1] : exl;
      sw_ip    <= w13 ? CP0WData[9:8] : sw_ip;
      exc_code <= take_int ? 5'd0 : take_sys ? 5'd8 : exc_code;
      bd       <= (exc && !exl) ? InDelaySlot : bd;
      epc      <= (exc && !exl) ? (InDelaySlot ? InstPC - 32'd4 : InstPC) : w14 ? CP0WData : epc;
      tgt      <= exc ? EXC_VECTOR : take_eret ? epc : tgt;
    end
  end
endmodule

// File: doc/cp0_exception_unit.md
# cp0_exception_unit

Coprocessor-0 register file and exception sequencer for the MIPS32 pipeline. The unit consumes the decoder's CP0 read/write strobes and the `ExcSyscall`/`ExcEret` flags for the instruction at the commit point. It also samples hardware interrupt lines and runs a Count/Compare timer. On a taken exception, interrupt or ERET it updates Status/Cause/EPC, then sequences a one-cycle pipeline flush followed by a held PC-redirect handshake to fetch.

## Interface
- `EXC_VECTOR`, 32'h0000_0080, redirect target for every exception and interrupt
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `InstValid`  in  1  commit-point instruction is valid
- `InstPC`  in  32  PC of commit-point instruction
- `InDelaySlot`  in  1  commit-point instruction is in a branch delay slot
- `ExcSyscall`, `ExcEret`  in  1 each  decoder exception flags
- `CP0WE`  in  1  MTC0 write strobe
- `CP0WAddr`  in  5  write register number
- `CP0WData`  in  32  write data
- `CP0RE`  in  1  MFC0 read strobe
- `CP0RAddr`  in  5  read register number
- `CP0RData`  out  32  read data, combinational
- `HwInt`  in  6  level-sensitive external interrupts
- `FlushReq`  out  1  kill all younger instructions
- `RedirectValid`  out  1  redirect request to fetch
- `RedirectPC`  out  32  redirect target
- `RedirectAck`  in  1  fetch accepted the redirect
- `Busy`  out  1  sequencer not IDLE; upstream stalls commit

## Operation
- Registers and reset values:
  - Count (9): reset 0.
  - Compare (11): reset 32'hFFFF_FFFF.
  - Status (12): reset 0. Fields: IE[0], EXL[1], IM[15:8]. Other bits read 0.
  - Cause (13): reset 0. Fields: BD[31], IP[15:8], ExcCode[6:2].
  - EPC (14): reset 0.
  - TimerPending: reset 0.
- Reads:
  - `CP0RData` = selected register when `CP0RE`=1, else 0.
  - Unimplemented register numbers read 0.
- Cause.IP is composed as follows:
  - IP[7] = `HwInt[5]` | TimerPending.
  - IP[6:2] = `HwInt[4:0]`, registered once per cycle.
  - IP[1:0] are software-writable.
  - Only IP[1:0] of Cause are writable by MTC0.
- Count behaviour:
  - Count increments every cycle; a write to Count overrides the increment that cycle.
  - Count==Compare sets TimerPending (sticky).
  - A write to Compare clears TimerPending. This write wins over a same-cycle match.
- IntPending = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- Event selection happens in IDLE when `InstValid`=1. Priority: interrupt > syscall > eret.
  - Interrupt:
    - ExcCode=0.
    - The commit instruction is cancelled and its `CP0WE` is suppressed.
  - Syscall: ExcCode=8.
  - For both interrupt and syscall, when EXL=0:
    - EPC = `InDelaySlot` ? `InstPC`-4 : `InstPC`.
    - BD = `InDelaySlot`.
  - For both, when EXL=1: EPC and BD are unchanged. ExcCode is still written.
  - For both: EXL←1, then target = `EXC_VECTOR`.
  - Eret: EXL←0; target = current EPC.
- FSM:
  - IDLE→FLUSH on event; target is latched.
  - FLUSH→REDIRECT unconditionally.
  - REDIRECT→IDLE on `RedirectAck`.
  - In FLUSH and REDIRECT, `InstValid`, `ExcSyscall`, `ExcEret` and `CP0WE` are ignored. Interrupts stay pending.
- Outputs:
  - `FlushReq`=1 only in FLUSH.
  - `RedirectValid`=1 only in REDIRECT.
  - `RedirectPC` holds the latched target stable in REDIRECT. It is 0 otherwise.
  - `Busy` = state≠IDLE.
- Reset values of outputs: `FlushReq`, `RedirectValid` and `Busy` are 0; `RedirectPC` is 0; `CP0RData` is 0.
- Reset mid-operation: FSM returns to IDLE, outputs go to 0, and the latched target is discarded.

## Timing
- Event accepted in cycle T:
  - Register updates are visible in T+1.
  - `FlushReq`=1 in T+1, for exactly one cycle.
  - `RedirectValid`=1 from T+2 until and including the `RedirectAck` cycle.
  - IDLE in the cycle after the ack. Minimum occupancy is 3 cycles (T+3 IDLE).
- MTC0 in cycle T is visible to MFC0 in T+1. No same-cycle bypass.
- A Status.IE/IM write in T affects IntPending from T+1.
- `HwInt` assertion in T is seen in Cause.IP at T+1. The earliest interrupt is taken in T+1.

## Test plan
- Syscall: Status=0x0000_0001, `InstPC`=0x100, `ExcSyscall`=1.
  - EPC=0x100, ExcCode=8, EXL=1.
  - Flush at T+1; redirect to 0x80 at T+2.
  - Ack at T+4 → IDLE at T+5.
- Delay-slot syscall with `InstPC`=0x204 → EPC=0x200, BD=1.
  - A second syscall taken with EXL=1 leaves EPC=0x200.
- Interrupt masking:
  - `HwInt[2]`=1 with Status=0x0000_0001 → not taken.
  - Status=0x0000_1001 → taken at the next valid instruction. ExcCode=0, and the same-cycle MTC0 is suppressed.
- Same-cycle interrupt and syscall: interrupt wins and ExcCode=0. Then ERET with EPC=0x300 → EXL=0 and redirect to 0x300.
- Timer:
  - Compare=20 with Count written to 10 → TimerPending after Count reaches 20; Cause.IP[7]=1.
  - Writing Compare clears it.
  - Writing Compare in the match cycle leaves TimerPending=0.
- Reset in REDIRECT state, before ack: all outputs 0 in the next cycle and `Busy`=0. Registers return to reset values.
